// File: rtl/delay_chain_pkg.sv
// Shared defaults for the register delay line used on the memory and read-data pipes.
package delay_chain_pkg;

  localparam int DEF_WORD_WDT    = 8;
  localparam int DEF_DEL_CYC_LEN = 1;

endpackage

// File: rtl/delay_chain.sv
// Clock-enabled register delay line for a data word plus side-band valid flag.
// A zero-length configuration is a plain combinational pass-through.
module delay_chain
  import delay_chain_pkg::*;
#(
  parameter int IN_WORD_WDT = DEF_WORD_WDT,
  parameter int DEL_CYC_LEN = DEF_DEL_CYC_LEN
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clk_en,
  input  logic [IN_WORD_WDT-1:0] in_word,
  input  logic                   in_word_val,
  output logic [IN_WORD_WDT-1:0] in_word_del,
  output logic                   in_word_val_del
);

  if (IN_WORD_WDT < 1) begin : g_bad_wdt
    $fatal(1, "delay_chain: IN_WORD_WDT must be >= 1");
  end

  if (DEL_CYC_LEN < 0) begin : g_bad_len
    $fatal(1, "delay_chain: DEL_CYC_LEN must be >= 0");
  end

  if (DEL_CYC_LEN == 0) begin : g_pass
    logic unused_ctrl;
    assign unused_ctrl     = &{1'b0, clk, rst_n, clk_en};
    assign in_word_del     = in_word;
    assign in_word_val_del = in_word_val;
  end else begin : g_chain
    // Valid rides in the top bit of each stage so both paths shift in lockstep.
    logic [IN_WORD_WDT:0] stage_q [DEL_CYC_LEN];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stage_q <= '{default: '0};
      end else if (clk_en) begin
        stage_q[0] <= {in_word_val, in_word};
        for (int unsigned k = 1; k < DEL_CYC_LEN; k++) begin
          stage_q[k] <= stage_q[k-1];
        end
      end
    end

    assign in_word_del     = stage_q[DEL_CYC_LEN-1][IN_WORD_WDT-1:0];
    assign in_word_val_del = stage_q[DEL_CYC_LEN-1][IN_WORD_WDT];
  end

endmodule

// File: tb/tb_delay_chain.sv
// Directed self-checking bench for delay_chain at lengths 0, 1, 3 and 5.
module tb_delay_chain;

  logic        clk = 1'b0;
  logic        clk_stop = 1'b0;
  logic        rst_n = 1'b1;
  logic        clk_en = 1'b1;

  logic [7:0]  w3 = '0;
  logic        v3 = 1'b0;
  logic [7:0]  w3_del;
  logic        v3_del;

  logic [7:0]  w0 = '0;
  logic        v0 = 1'b0;
  logic [7:0]  w0_del;
  logic        v0_del;

  logic [63:0] w1 = '0;
  logic        v1 = 1'b0;
  logic [63:0] w1_del;
  logic        v1_del;

  logic [7:0]  w5 = '0;
  logic        v5 = 1'b0;
  logic [7:0]  w5_del;
  logic        v5_del;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  delay_chain #(.IN_WORD_WDT(8), .DEL_CYC_LEN(3)) u_len3 (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .in_word(w3), .in_word_val(v3), .in_word_del(w3_del), .in_word_val_del(v3_del)
  );

  delay_chain #(.IN_WORD_WDT(8), .DEL_CYC_LEN(0)) u_len0 (
    .clk(clk_stop), .rst_n(rst_n), .clk_en(clk_en),
    .in_word(w0), .in_word_val(v0), .in_word_del(w0_del), .in_word_val_del(v0_del)
  );

  delay_chain #(.IN_WORD_WDT(64), .DEL_CYC_LEN(1)) u_len1 (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .in_word(w1), .in_word_val(v1), .in_word_del(w1_del), .in_word_val_del(v1_del)
  );

  delay_chain #(.IN_WORD_WDT(8), .DEL_CYC_LEN(5)) u_len5 (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .in_word(w5), .in_word_val(v5), .in_word_del(w5_del), .in_word_val_del(v5_del)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0]  en_tab  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [7:0]  in_tab  [5] = '{8'hA5, 8'h5A, 8'h5A, 8'h5A, 8'h5A};
  logic [7:0]  exp_tab [5] = '{8'h07, 8'h07, 8'h07, 8'h08, 8'hA5};
  logic [7:0]  rel_in  [3] = '{8'h11, 8'h22, 8'h33};
  logic [7:0]  rel_exp [3] = '{8'h00, 8'h00, 8'h11};
  logic        rel_vex [3] = '{1'b0, 1'b0, 1'b1};

  initial begin
    logic [63:0] prev_w;
    logic        prev_v;

    // reset state
    w0 = 8'h3C;
    v0 = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_len3_data", 64'(w3_del), 64'h0);
    check("rst_len3_val",  64'(v3_del), 64'h0);
    check("rst_len1_data", w1_del, 64'h0);
    check("rst_len5_val",  64'(v5_del), 64'h0);
    check("len0_in_reset_data", 64'(w0_del), 64'h3C);
    check("len0_in_reset_val",  64'(v0_del), 64'h1);
    @(negedge clk);
    rst_n = 1'b1;

    // ramp through length-3 chain
    for (int i = 1; i <= 8; i++) begin
      w3 = 8'(i);
      v3 = 1'b1;
      step();
      check("ramp_data", 64'(w3_del), (i >= 3) ? 64'(i - 2) : 64'h0);
      check("ramp_val",  64'(v3_del), (i >= 3) ? 64'h1 : 64'h0);
    end

    // clock-enable gating: stages hold on disabled edges
    for (int i = 0; i < 5; i++) begin
      clk_en = en_tab[i][0];
      w3     = in_tab[i];
      step();
      check("en_gate_data", 64'(w3_del), 64'(exp_tab[i]));
      check("en_gate_val",  64'(v3_del), 64'h1);
    end
    clk_en = 1'b1;

    // fill with 0xFF, then async reset between edges
    for (int i = 0; i < 3; i++) begin
      w3 = 8'hFF;
      step();
    end
    check("full_ff", 64'(w3_del), 64'hFF);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_data", 64'(w3_del), 64'h0);
    check("async_rst_val",  64'(v3_del), 64'h0);
    check("len0_ignores_rst", 64'(w0_del), 64'h3C);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      w3 = rel_in[i];
      v3 = 1'b1;
      step();
      check("refill_data", 64'(w3_del), 64'(rel_exp[i]));
      check("refill_val",  64'(v3_del), 64'(rel_vex[i]));
    end

    // zero-length pass-through, no clock involved
    w0 = 8'hC3;
    v0 = 1'b0;
    #1;
    check("len0_data", 64'(w0_del), 64'hC3);
    check("len0_val",  64'(v0_del), 64'h0);
    w0 = 8'h3C;
    v0 = 1'b1;
    #1;
    check("len0_data2", 64'(w0_del), 64'h3C);
    check("len0_val2",  64'(v0_del), 64'h1);

    // length-1, 64-bit random words; valid does not gate data
    prev_w = w1_del;
    prev_v = v1_del;
    for (int i = 0; i < 20; i++) begin
      w1 = {$urandom(), $urandom()};
      v1 = 1'($urandom_range(0, 1));
      if (i == 0) v1 = 1'b0;
      prev_w = w1;
      prev_v = v1;
      step();
      check("len1_data", w1_del, prev_w);
      check("len1_val",  64'(v1_del), 64'(prev_v));
    end

    // length-5 single valid pulse
    for (int j = 1; j <= 12; j++) begin
      w5 = 8'(j);
      v5 = (j == 1);
      step();
      check("len5_data", 64'(w5_del), (j >= 5) ? 64'(j - 4) : 64'h0);
      check("len5_pulse", 64'(v5_del), (j == 5) ? 64'h1 : 64'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/delay_chain.md
Name: delay_chain

Overview:
- Generic parameterizable register delay line.
- Delays a data word and an accompanying valid flag by a fixed number of clock-enabled cycles.
- Used throughout the design for input/output pipelining, e.g. the memory address/data/enable paths and read-data output pipes.
- Zero-length configuration degenerates to a combinational pass-through.

Parameters:
- IN_WORD_WDT, 8, width in bits of the data word (>=1).
- DEL_CYC_LEN, 1, number of register stages (>=0; 0 = pass-through).

Ports:
- clk, input, 1, single clock; all stages update on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- clk_en, input, 1, stage enable; all stages advance only when high.
- in_word, input, IN_WORD_WDT, data word entering the chain.
- in_word_val, input, 1, valid flag travelling alongside in_word; may be left open by integrators who do not use it.
- in_word_del, output, IN_WORD_WDT, in_word delayed by DEL_CYC_LEN enabled cycles.
- in_word_val_del, output, 1, in_word_val delayed identically; may be left open.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Structure for DEL_CYC_LEN>0: DEL_CYC_LEN data stages and DEL_CYC_LEN valid stages.
  - Stage 0 loads in_word/in_word_val.
  - Stage k loads stage k-1.
  - Outputs are driven from the last stage (registered outputs).
- Reset:
  - rst_n low immediately clears all data stages to 0 and all valid stages to 0, independent of clk/clk_en.
  - Therefore in_word_del=0 and in_word_val_del=0 during and after reset until new data propagates.
- clk_en high at a rising edge: every stage shifts by one.
- clk_en low: every stage holds its value; outputs unchanged.
  - Latency is counted in enabled edges, not raw cycles.
- Data stages shift unconditionally on enabled edges. They are not gated by in_word_val; the valid flag is purely side-band.
- Latency: a word presented before enabled edge n appears at the outputs right after enabled edge n+DEL_CYC_LEN-1. Total DEL_CYC_LEN enabled edges.
- Throughput: one word per enabled edge, no bubbles, no backpressure.
- DEL_CYC_LEN=0:
  - in_word_del = in_word and in_word_val_del = in_word_val, combinationally.
  - No registers; rst_n and clk_en have no effect.
- Reset released mid-stream: chain refills from zeros. The first DEL_CYC_LEN-1 enabled edges after release output the zeroed contents.
- Widths are preserved exactly; no arithmetic, sign handling or truncation.
- Simulation-only checks, excluded from synthesis:
  - Fatal error if IN_WORD_WDT<1.
  - Fatal error if DEL_CYC_LEN<0.

Decomposition:
- No package types needed; parameters are plain integers.
- Single module implemented with a generate branch (length zero vs. length>0) and a stage array.
- No sub-module.

Test Plan:
- DEL_CYC_LEN=3, IN_WORD_WDT=8, clk_en=1, in_word ramp 0x01,0x02,0x03… with in_word_val=1 -> in_word_del shows 0x00 for the first 2 edges after the first load, then 0x01,0x02,… exactly 3 edges after input; in_word_val_del rises 3 edges after in_word_val.
- DEL_CYC_LEN=3, toggle clk_en 1,0,0,1,1 while feeding 0xA5 then 0x5A -> outputs hold on disabled edges; 0xA5 emerges after the third enabled edge, not the third raw edge.
- Assert rst_n low asynchronously mid-stream, between clock edges, with chain full of 0xFF -> in_word_del=0 and in_word_val_del=0 immediately; after release, zeros drain for 2 enabled edges before new data appears.
- DEL_CYC_LEN=0, in_word=0x3C, in_word_val=1, clk stopped -> in_word_del=0x3C and in_word_val_del=1 with zero latency; reset has no effect.
- DEL_CYC_LEN=1, IN_WORD_WDT=64, random words every cycle with in_word_val random -> in_word_del equals the previous enabled cycle's in_word bit-exactly; the valid flag does not gate data.
- DEL_CYC_LEN=5, in_word_val pulse of one cycle -> in_word_val_del single-cycle pulse exactly 5 enabled edges later; no other pulses.
